// File: rtl/tcam_lookup_ctrl.sv
// Request-side controller for a 16-entry ternary CAM: init sweep, then
// serialised write/search requests with a held search response and hit/miss counters.
module tcam_lookup_ctrl #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 4,
    parameter int                SEARCH_LAT = 1,
    parameter logic [DATA_W-1:0] INIT_KEY   = 16'hFFFF,
    parameter int                CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_key,
    input  logic [DATA_W-1:0] req_mask,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              init_done,
    output logic [DATA_W-1:0] tcam_data,
    output logic [DATA_W-1:0] tcam_dontcare,
    output logic [ADDR_W-1:0] tcam_write_address,
    output logic              tcam_write_readN,
    input  logic [ADDR_W-1:0] tcam_found_address,
    input  logic              tcam_found_any
);

    localparam int LAT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(SEARCH_LAT - 1);
    localparam logic [ADDR_W:0]   N_ENT    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_SEARCH,
        S_RESP
    } state_t;

    state_t              r_state,  w_state;
    logic [ADDR_W:0]     r_icnt,   w_icnt;
    logic [LAT_W-1:0]    r_lat,    w_lat;
    logic                r_req_ready, w_req_ready;
    logic                r_rsp_valid, w_rsp_valid;
    logic                r_rsp_hit,   w_rsp_hit;
    logic [ADDR_W-1:0]   r_rsp_addr,  w_rsp_addr;
    logic [CNT_W-1:0]    r_hit,    w_hit;
    logic [CNT_W-1:0]    r_miss,   w_miss;
    logic                r_init_done, w_init_done;
    logic [DATA_W-1:0]   r_data,   w_data;
    logic [DATA_W-1:0]   r_dc,     w_dc;
    logic [ADDR_W-1:0]   r_waddr,  w_waddr;
    logic                r_wr,     w_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_icnt      <= '0;
            r_lat       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_addr  <= '0;
            r_hit       <= '0;
            r_miss      <= '0;
            r_init_done <= 1'b0;
            r_data      <= '0;
            r_dc        <= '0;
            r_waddr     <= '0;
            r_wr        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_icnt      <= w_icnt;
            r_lat       <= w_lat;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_hit   <= w_rsp_hit;
            r_rsp_addr  <= w_rsp_addr;
            r_hit       <= w_hit;
            r_miss      <= w_miss;
            r_init_done <= w_init_done;
            r_data      <= w_data;
            r_dc        <= w_dc;
            r_waddr     <= w_waddr;
            r_wr        <= w_wr;
        end
    end

    // Every output is a register; this block computes their next values.
    always_comb begin
        w_state     = r_state;
        w_icnt      = r_icnt;
        w_lat       = r_lat;
        w_req_ready = r_req_ready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_hit   = r_rsp_hit;
        w_rsp_addr  = r_rsp_addr;
        w_hit       = r_hit;
        w_miss      = r_miss;
        w_init_done = r_init_done;
        w_data      = r_data;
        w_dc        = r_dc;
        w_waddr     = r_waddr;
        w_wr        = 1'b0;
        unique case (r_state)
            S_INIT: begin
                if (r_icnt == N_ENT) begin
                    w_init_done = 1'b1;
                    w_req_ready = 1'b1;
                    w_state     = S_IDLE;
                end else begin
                    w_wr    = 1'b1;
                    w_data  = INIT_KEY;
                    w_dc    = '0;
                    w_waddr = r_icnt[ADDR_W-1:0];
                    w_icnt  = r_icnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_req_ready = 1'b0;
                    w_data      = req_key;
                    if (req_write) begin
                        w_dc    = req_mask;
                        w_waddr = req_addr;
                        w_wr    = 1'b1;
                        w_state = S_WRITE;
                    end else begin
                        w_dc    = '0;
                        w_lat   = LAT_LOAD;
                        w_state = S_SEARCH;
                    end
                end
            end
            S_WRITE: begin
                w_req_ready = 1'b1;
                w_state     = S_IDLE;
            end
            S_SEARCH: begin
                if (r_lat == '0) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_hit   = tcam_found_any;
                    w_rsp_addr  = tcam_found_any ? tcam_found_address : '0;
                    if (tcam_found_any) begin
                        if (r_hit != '1) w_hit = r_hit + 1'b1;
                    end else begin
                        if (r_miss != '1) w_miss = r_miss + 1'b1;
                    end
                    w_state = S_RESP;
                end else begin
                    w_lat = r_lat - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_INIT;
        endcase
    end

    assign req_ready          = r_req_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_hit            = r_rsp_hit;
    assign rsp_addr           = r_rsp_addr;
    assign hit_cnt            = r_hit;
    assign miss_cnt           = r_miss;
    assign init_done          = r_init_done;
    assign tcam_data          = r_data;
    assign tcam_dontcare      = r_dc;
    assign tcam_write_address = r_waddr;
    assign tcam_write_readN   = r_wr;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Bench for tcam_lookup_ctrl: behavioural CAM, table-level reference model,
// directed scenarios followed by randomized write/search traffic.
module tb_tcam_lookup_ctrl;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_key, req_mask;
    logic [3:0]  req_addr;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [3:0]  rsp_addr;
    logic [7:0]  hit_cnt, miss_cnt;
    logic        init_done;
    logic [15:0] tcam_data, tcam_dontcare;
    logic [3:0]  tcam_write_address;
    logic        tcam_write_readN;
    logic [3:0]  tcam_found_address;
    logic        tcam_found_any;

    int checks = 0;
    int fails  = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    bit [15:0] ref_key [16];
    bit [15:0] ref_msk [16];

    always #5 clk = ~clk;

    tcam_lookup_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_key(req_key), .req_mask(req_mask), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .init_done(init_done),
        .tcam_data(tcam_data), .tcam_dontcare(tcam_dontcare),
        .tcam_write_address(tcam_write_address),
        .tcam_write_readN(tcam_write_readN),
        .tcam_found_address(tcam_found_address),
        .tcam_found_any(tcam_found_any)
    );

    // Behavioural CAM: writes land on the sampling edge, search answer is
    // combinational on the driven key (one cycle of latency), lowest index wins.
    logic [15:0] cam_key [16];
    logic [15:0] cam_dc  [16];

    always @(posedge clk)
        if (tcam_write_readN) begin
            cam_key[tcam_write_address] <= tcam_data;
            cam_dc[tcam_write_address]  <= tcam_dontcare;
        end

    always_comb begin
        tcam_found_any     = 1'b0;
        tcam_found_address = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (((tcam_data ^ cam_key[i]) & ~cam_dc[i]) == 16'h0) begin
                tcam_found_any     = 1'b1;
                tcam_found_address = 4'(i);
            end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_search(input bit [15:0] key,
                                         output bit hit, output bit [3:0] a);
        hit = 1'b0;
        a   = 4'd0;
        for (int e = 0; e < 16; e++)
            if (!hit && ((key ^ ref_key[e]) & ~ref_msk[e]) == 16'h0) begin
                hit = 1'b1;
                a   = 4'(e);
            end
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init();
        for (int i = 0; i < 16; i++) begin
            step();
            chk("init_write",
                64'({req_ready, init_done, tcam_write_readN, tcam_write_address,
                     tcam_data, tcam_dontcare}),
                64'({1'b0, 1'b0, 1'b1, 4'(i), 16'hFFFF, 16'h0000}));
        end
        step();
        chk("init_done", 64'({tcam_write_readN, init_done, req_ready}),
            64'(3'b011));
        for (int e = 0; e < 16; e++) begin
            ref_key[e] = 16'hFFFF;
            ref_msk[e] = 16'h0000;
        end
    endtask

    task automatic issue(input bit w, input bit [15:0] k, input bit [15:0] m,
                         input bit [3:0] a);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_key   = k;
        req_mask  = m;
        req_addr  = a;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (req_ready) ok = 1'b1;
            step();
        end
        req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_write(input bit [3:0] a, input bit [15:0] k,
                            input bit [15:0] m);
        issue(1'b1, k, m, a);
        chk("write_drive",
            64'({tcam_write_readN, tcam_write_address, tcam_data, tcam_dontcare,
                 req_ready}),
            64'({1'b1, a, k, m, 1'b0}));
        ref_key[a] = k;
        ref_msk[a] = m;
        step();
        chk("write_end", 64'({tcam_write_readN, req_ready}), 64'(2'b01));
    endtask

    task automatic do_search(input bit [15:0] key, input int rdelay,
                             output bit ohit, output bit [3:0] oaddr);
        bit eh;
        bit [3:0] ea;
        int lat = 0;
        model_search(key, eh, ea);
        issue(1'b0, key, 16'($urandom), 4'($urandom));
        chk("search_drive",
            64'({tcam_write_readN, tcam_data, tcam_dontcare, req_ready}),
            64'({1'b0, key, 16'h0000, 1'b0}));
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("search_latency", 64'(lat), 64'(LAT));
        if (eh) exp_hit = sat_inc(exp_hit);
        else    exp_miss = sat_inc(exp_miss);
        chk("search_rsp", 64'({rsp_valid, rsp_hit, rsp_addr}),
            64'({1'b1, eh, ea}));
        chk("search_cnt", 64'({hit_cnt, miss_cnt}),
            64'({8'(exp_hit), 8'(exp_miss)}));
        ohit  = rsp_hit;
        oaddr = rsp_addr;
        for (int d = 0; d < rdelay; d++) begin
            step();
            chk("rsp_hold", 64'({rsp_valid, rsp_hit, rsp_addr, req_ready}),
                64'({1'b1, eh, ea, 1'b0}));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_handshake", 64'({rsp_valid, req_ready}), 64'(2'b01));
    endtask

    initial begin
        bit h;
        bit [3:0] a;
        bit eh;
        bit [3:0] ea;
        bit [15:0] k;
        int e;
        int lat;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_key   = '0;
        req_mask  = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;

        // 1: reset values and init sweep
        repeat (3) step();
        chk("reset_outputs",
            64'({req_ready, rsp_valid, rsp_hit, rsp_addr, hit_cnt, miss_cnt,
                 init_done, tcam_write_readN, tcam_write_address}),
            64'(0));
        chk("reset_bus", 64'({tcam_data, tcam_dontcare}), 64'(0));
        reset = 1'b0;
        check_init();

        // 2: masked write then hitting search
        do_write(4'd14, 16'h6EEA, 16'h8787);
        do_search(16'hE96C, 0, h, a);
        chk("t2_hit", 64'({h, a}), 64'({1'b1, 4'd14}));
        chk("t2_hit_cnt", 64'(hit_cnt), 64'(1));

        // 3: wide mask entry
        do_write(4'd8, 16'h8000, 16'h3FFF);
        do_search(16'h92B5, 1, h, a);
        chk("t3_hit", 64'({h, a}), 64'({1'b1, 4'd8}));

        // 4: miss
        do_search(16'h0000, 2, h, a);
        chk("t4_miss", 64'({h, a, miss_cnt, hit_cnt}),
            64'({1'b0, 4'd0, 8'd1, 8'd2}));

        // 5: backpressure with a competing request
        model_search(16'h0000, eh, ea);
        issue(1'b0, 16'h0000, 16'h0, 4'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        exp_miss = sat_inc(exp_miss);
        chk("t5_rsp", 64'({rsp_valid, rsp_hit, rsp_addr, miss_cnt}),
            64'({1'b1, eh, ea, 8'(exp_miss)}));
        req_valid = 1'b1;
        req_write = 1'b1;
        req_key   = 16'h1234;
        req_mask  = 16'h0000;
        req_addr  = 4'd3;
        for (int d = 0; d < 5; d++) begin
            step();
            chk("t5_hold",
                64'({rsp_valid, rsp_hit, rsp_addr, req_ready, tcam_write_readN}),
                64'({1'b1, eh, ea, 1'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t5_handshake", 64'({rsp_valid, req_ready, tcam_write_readN}),
            64'(3'b010));
        step();
        req_valid = 1'b0;
        chk("t5_accept",
            64'({tcam_write_readN, tcam_write_address, tcam_data, req_ready}),
            64'({1'b1, 4'd3, 16'h1234, 1'b0}));
        ref_key[3] = 16'h1234;
        ref_msk[3] = 16'h0000;
        step();
        chk("t5_write_end", 64'({tcam_write_readN, req_ready}), 64'(2'b01));

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                do_write(4'($urandom), 16'($urandom),
                         16'($urandom) & 16'($urandom));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    e = $urandom_range(0, 15);
                    k = ref_key[e] ^ (16'($urandom) & ref_msk[e]);
                end else begin
                    k = 16'($urandom);
                end
                do_search(k, $urandom_range(0, 3), h, a);
            end
        end

        // hit counter saturation
        for (int n = 0; n < 260; n++) begin
            e = $urandom_range(0, 15);
            k = ref_key[e] ^ (16'($urandom) & ref_msk[e]);
            do_search(k, 0, h, a);
        end
        chk("hit_saturated", 64'(hit_cnt), 64'(255));

        // 6: reset in the middle of a search
        issue(1'b0, 16'hFFFF, 16'h0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_reset",
            64'({rsp_valid, req_ready, init_done, tcam_write_readN, hit_cnt,
                 miss_cnt, tcam_data}),
            64'(0));
        repeat (3) step();
        reset = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        check_init();
        do_search(16'hFFFF, 1, h, a);
        chk("t6_post_hit", 64'({h, a, hit_cnt, miss_cnt}),
            64'({1'b1, 4'd0, 8'd1, 8'd0}));
        do_search(16'h0F0F, 0, h, a);
        chk("t6_post_miss", 64'({h, miss_cnt}), 64'({1'b0, 8'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
